mul_sched_rr: RTL and testbench

Round-robin scheduler that shares one 128b x 128b KO multiplier (3 compute cycles, single-cycle start pulse, one-cycle finish pulse) among up to N_REQ requesters, e.g. point-add and point-double units of the SM2 core. It arbitrates requests, latches the winner's operands, sequences the multiplier's start/finish protocol, and returns the 256b product with the requester's ID.

---
 rtl/mul_sched_pkg.sv | 20 ++
 rtl/mul_sched_rr_arb.sv | 46 ++++
 rtl/mul_sched_rr.sv | 191 +++++++++++++++++++
 tb/tb_mul_sched_rr.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared types and constants for the round-robin multiplier
// scheduler (mul_sched_rr) and its arbiter (rr_arb).
//   state_e  : scheduler states IDLE/ISSUE/BUSY/FIN (0..3)
//   OP_W     : multiplier operand width
//   PROD_W   : multiplier product width
//   MUL_LAT  : multiplier compute latency in cycles
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam int unsigned OP_W    = 128;
  localparam int unsigned PROD_W  = 256;
  localparam int unsigned MUL_LAT = 3;

endpackage

// File: rtl/mul_sched_rr_arb.sv
// rr_arb: round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : request vector
//   adv_i      : arbitration enable; pointer moves only when it grants
//   gnt_o      : one-hot grant (combinational)
//   idx_o      : index of the granted requester
// The last-grant pointer resets to N_REQ-1 so requester 0 wins first.
module rr_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             adv_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);

  logic [ID_W-1:0] last_q, last_d;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    // Scan starting one past the last grant, wrapping around.
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      int unsigned c;
      c = (32'(last_q) + off) % N_REQ;
      if (!found && req_i[ID_W'(c)]) begin
        found               = 1'b1;
        gnt_o[ID_W'(c)]     = 1'b1;
        idx_o               = ID_W'(c);
      end
    end
    last_d = last_q;
    if (adv_i && found) last_d = idx_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= ID_W'(N_REQ - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mul_sched_rr.sv
// mul_sched_rr: round-robin scheduler sharing one 128x128 multiplier
// (3 compute cycles, start pulse, finish pulse) among N_REQ requesters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_vld_i/a_i/b_i   : per-requester request and packed operands
//   req_gnt_o           : one-hot grant, operands sampled that cycle
//   rsp_vld_o/id_o/r_o  : one-cycle response strobe, ID and product
//   mul_vld_o/a_o/b_o   : multiplier start pulse and operands
//   mul_fin_i/r_i       : multiplier finish pulse and product
// Optional feature macro MUL_SCHED_OVERLAP_EN: arbitrate in the last
// multiplier cycle so the next issue coincides with the finish pulse
// (issue period 3 instead of 5).
module mul_sched_rr
  import mul_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_vld_i,
  input  logic [N_REQ*OP_W-1:0] req_a_i,
  input  logic [N_REQ*OP_W-1:0] req_b_i,
  output logic [N_REQ-1:0]      req_gnt_o,
  output logic [N_REQ-1:0]      rsp_vld_o,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [PROD_W-1:0]     rsp_r_o,
  output logic                  mul_vld_o,
  output logic [OP_W-1:0]       mul_a_o,
  output logic [OP_W-1:0]       mul_b_o,
  input  logic                  mul_fin_i,
  input  logic [PROD_W-1:0]     mul_r_i
);

  localparam logic [1:0] CNT_LAST = 2'(MUL_LAT - 1);
  localparam logic [1:0] CNT_SAT  = 2'd3;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [OP_W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [PROD_W-1:0]   rsp_r_q, rsp_r_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [N_REQ-1:0]    rsp_vld_q, rsp_vld_d;
  logic                arb_en, grant, cap;
  logic [N_REQ-1:0]    arb_gnt;
  logic [ID_W-1:0]     arb_idx, cap_id;
  logic [OP_W-1:0]     sel_a, sel_b;
`ifdef MUL_SCHED_OVERLAP_EN
  logic [ID_W-1:0]     fin_id_q, fin_id_d;
  logic                fin_pend_q, fin_pend_d;
`endif

  always_comb begin
    arb_en = (state_q == IDLE) || (state_q == FIN);
`ifdef MUL_SCHED_OVERLAP_EN
    arb_en = arb_en || ((state_q == BUSY) && (cnt_q == CNT_LAST));
`endif
  end

  rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_vld_i & {N_REQ{arb_en}}),
    .adv_i (arb_en),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign grant     = |arb_gnt;
  assign req_gnt_o = arb_gnt;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (arb_gnt[k]) begin
        sel_a = req_a_i[k*OP_W +: OP_W];
        sel_b = req_b_i[k*OP_W +: OP_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, FIN: state_d = grant ? ISSUE : IDLE;
      ISSUE:     state_d = BUSY;
      BUSY: begin
`ifdef MUL_SCHED_OVERLAP_EN
        if (grant)          state_d = ISSUE;
        else if (mul_fin_i) state_d = FIN;
`else
        if (mul_fin_i) state_d = FIN;
`endif
      end
      default:   state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mul_vld_o = (state_q == ISSUE);
    mul_a_o   = op_a_q;
    mul_b_o   = op_b_q;
    rsp_vld_o = rsp_vld_q;
    rsp_id_o  = rsp_id_q;
    rsp_r_o   = rsp_r_q;
  end

  // Datapath next values
  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    id_d   = id_q;
    if (grant) begin
      op_a_d = sel_a;
      op_b_d = sel_b;
      id_d   = arb_idx;
    end

    // cnt reads 0 in ISSUE and counts multiplier cycles, saturating.
    cnt_d = cnt_q;
    if (state_d == ISSUE) cnt_d = '0;
    else if (((state_q == ISSUE) || (state_q == BUSY)) && (cnt_q != CNT_SAT))
      cnt_d = cnt_q + 2'd1;

    cap    = (state_q == BUSY) && mul_fin_i;
    cap_id = id_q;
`ifdef MUL_SCHED_OVERLAP_EN
    // A grant in BUSY overwrites id_q, so the in-flight id moves to fin_id
    // and its product is captured during the following ISSUE cycle.
    fin_id_d   = fin_id_q;
    fin_pend_d = (state_q == BUSY) && grant && !mul_fin_i;
    if ((state_q == BUSY) && grant) fin_id_d = id_q;
    if ((state_q == ISSUE) && fin_pend_q && mul_fin_i) begin
      cap    = 1'b1;
      cap_id = fin_id_q;
    end
`endif

    rsp_vld_d = '0;
    rsp_r_d   = rsp_r_q;
    rsp_id_d  = rsp_id_q;
    if (cap) begin
      rsp_r_d  = mul_r_i;
      rsp_id_d = cap_id;
      for (int unsigned k = 0; k < N_REQ; k++)
        rsp_vld_d[k] = (cap_id == ID_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      id_q      <= '0;
      rsp_r_q   <= '0;
      rsp_id_q  <= '0;
      rsp_vld_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      id_q      <= id_d;
      rsp_r_q   <= rsp_r_d;
      rsp_id_q  <= rsp_id_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

`ifdef MUL_SCHED_OVERLAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_id_q   <= '0;
      fin_pend_q <= 1'b0;
    end else begin
      fin_id_q   <= fin_id_d;
      fin_pend_q <= fin_pend_d;
    end
  end
`endif

endmodule

// File: tb/tb_mul_sched_rr.sv
// tb_mul_sched_rr: self-checking bench for mul_sched_rr with a behavioural
// multiplier (samples operands on its second cycle, finishes 3 cycles after
// start) and a transaction-level scheduler model.
module tb_mul_sched_rr;

  localparam int N  = 4;
  localparam int IW = 2;
`ifdef MUL_SCHED_OVERLAP_EN
  localparam int PERIOD = 3;
  localparam int STAB   = 2;
`else
  localparam int PERIOD = 5;
  localparam int STAB   = 4;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_vld_i = '0;
  logic [N*128-1:0] req_a_i = '0, req_b_i = '0;
  logic [N-1:0]     req_gnt_o, rsp_vld_o;
  logic [IW-1:0]    rsp_id_o;
  logic [255:0]     rsp_r_o;
  logic             mul_vld_o;
  logic [127:0]     mul_a_o, mul_b_o;
  logic             mul_fin_i = 1'b0;
  logic [255:0]     mul_r_i = '0;

  mul_sched_rr #(.N_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld_i(req_vld_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_gnt_o(req_gnt_o), .rsp_vld_o(rsp_vld_o), .rsp_id_o(rsp_id_o),
    .rsp_r_o(rsp_r_o), .mul_vld_o(mul_vld_o), .mul_a_o(mul_a_o),
    .mul_b_o(mul_b_o), .mul_fin_i(mul_fin_i), .mul_r_i(mul_r_i)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [255:0] prod(input logic [127:0] a, input logic [127:0] b);
    return {128'b0, a} * {128'b0, b};
  endfunction

  typedef struct { logic [127:0] a; logic [127:0] b; } op_t;
  typedef struct { int g; int id; logic [127:0] a; logic [127:0] b; } exp_t;
  typedef struct { int st; logic [127:0] a; logic [127:0] b; } job_t;

  op_t  rq [N][$];
  exp_t eq [$];
  job_t mq [$];
  logic [N-1:0] gnt_seen = '0;
  int glog_c[$], glog_id[$], rlog_c[$], rlog_id[$], mlog_c[$];
  logic [255:0] rlog_r[$];

  // Requester driver: pop on grant, re-assert next item, junk when idle.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (gnt_seen[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        req_vld_i[k] = (rq[k].size() > 0);
        if (rq[k].size() > 0) begin
          req_a_i[k*128 +: 128] = rq[k][0].a;
          req_b_i[k*128 +: 128] = rq[k][0].b;
        end else begin
          req_a_i[k*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
          req_b_i[k*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      end
    end
  end

  // Multiplier model: deliberately not reset, so an in-flight op yields a stray finish.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mq.size() > 0 && mq[0].st + 3 == cyc) begin
        mul_fin_i = 1'b1;
        mul_r_i   = prod(mq[0].a, mq[0].b);
        void'(mq.pop_front());
      end else begin
        mul_fin_i = 1'b0;
        mul_r_i   = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(negedge clk);
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].st + 1 == cyc) begin
          mq[i].a = mul_a_o;
          mq[i].b = mul_b_o;
        end
      if (mul_vld_o) mq.push_back('{st: cyc, a: '0, b: '0});
    end
  end

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (p + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  // Compare process: scheduler model checked every cycle.
  initial begin : mon
    int  ptr, last_g, w;
    bit  free;
    ptr = N - 1;
    last_g = -100;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_gnt", 256'(req_gnt_o), '0);
        chk("rst_rsp_vld", 256'(rsp_vld_o), '0);
        chk("rst_rsp_id", 256'(rsp_id_o), '0);
        chk("rst_rsp_r", rsp_r_o, '0);
        chk("rst_mul_vld", 256'(mul_vld_o), '0);
        chk("rst_mul_a", 256'(mul_a_o), '0);
        chk("rst_mul_b", 256'(mul_b_o), '0);
        ptr = N - 1;
        last_g = -100;
        eq.delete();
        gnt_seen = '0;
        continue;
      end
      gnt_seen = req_gnt_o;
      if (mul_vld_o) mlog_c.push_back(cyc);
      chk("mul_vld", 256'(mul_vld_o), 256'(cyc == last_g + 1));
      foreach (eq[i])
        if (cyc > eq[i].g && cyc <= eq[i].g + STAB) begin
          chk("mul_a_stable", 256'(mul_a_o), 256'(eq[i].a));
          chk("mul_b_stable", 256'(mul_b_o), 256'(eq[i].b));
        end
      if (eq.size() > 0 && eq[0].g + 5 == cyc) begin
        chk("rsp_vld", 256'(rsp_vld_o), 256'(1) << eq[0].id);
        chk("rsp_id", 256'(rsp_id_o), 256'(eq[0].id));
        chk("rsp_r", rsp_r_o, prod(eq[0].a, eq[0].b));
        void'(eq.pop_front());
      end else begin
        chk("rsp_idle", 256'(rsp_vld_o), '0);
      end
      if (rsp_vld_o != '0) begin
        rlog_c.push_back(cyc);
        rlog_id.push_back(int'(rsp_id_o));
        rlog_r.push_back(rsp_r_o);
      end
      free = (cyc >= last_g + 5);
`ifdef MUL_SCHED_OVERLAP_EN
      free = free || (cyc == last_g + 3);
`endif
      if (free && req_vld_i != '0) begin
        w = rr_pick(req_vld_i, ptr);
        chk("grant", 256'(req_gnt_o), 256'(1) << w);
        ptr = w;
        last_g = cyc;
        eq.push_back('{g: cyc, id: w, a: req_a_i[w*128 +: 128], b: req_b_i[w*128 +: 128]});
        glog_c.push_back(cyc);
        glog_id.push_back(w);
      end else begin
        chk("no_grant", 256'(req_gnt_o), '0);
      end
    end
  end

  task automatic clear_logs();
    glog_c.delete(); glog_id.delete(); rlog_c.delete();
    rlog_id.delete(); rlog_r.delete(); mlog_c.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) rq[k].delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_done(input string nm, input int max);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < max) begin
      @(posedge clk); #2;
      n++;
      busy = (eq.size() > 0) || (mq.size() > 0);
      for (int k = 0; k < N; k++) if (rq[k].size() > 0) busy = 1'b1;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: still busy after %0d cycles, expected idle", nm, max);
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    int g;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single request with all-ones operands.
    clear_logs();
    rq[0].push_back('{a: '1, b: '1});
    wait_done("single", 60);
    chk("single_ngnt", 256'(glog_id.size()), 256'(1));
    if (glog_id.size() == 1 && rlog_c.size() == 1 && mlog_c.size() == 1) begin
      chk("single_id", 256'(glog_id[0]), 256'(0));
      chk("single_issue", 256'(mlog_c[0] - glog_c[0]), 256'(1));
      chk("single_lat", 256'(rlog_c[0] - glog_c[0]), 256'(5));
      chk("single_r", rlog_r[0],
          256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001);
      chk("single_rid", 256'(rlog_id[0]), 256'(0));
    end

    // All four requesting, requester 0 twice.
    do_reset();
    rq[0].push_back('{a: 128'd1, b: 128'd3});
    rq[0].push_back('{a: 128'd1, b: 128'd3});
    rq[1].push_back('{a: 128'd2, b: 128'd3});
    rq[2].push_back('{a: 128'd3, b: 128'd3});
    rq[3].push_back('{a: 128'd4, b: 128'd3});
    wait_done("multi", 120);
    chk("multi_ngnt", 256'(rlog_r.size()), 256'(5));
    if (glog_id.size() == 5 && rlog_r.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("multi_gid", 256'(glog_id[i]), 256'(i % 4));
        chk("multi_rid", 256'(rlog_id[i]), 256'(i % 4));
        chk("multi_r", rlog_r[i], 256'(3 * ((i % 4) + 1)));
        if (i > 0) chk("multi_gap", 256'(rlog_c[i] - rlog_c[i-1]), 256'(PERIOD));
      end
    end

    // Fairness: 1 and 2 each re-asserted after every grant.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rq[1].push_back('{a: 128'(10 + i), b: 128'd2});
      rq[2].push_back('{a: 128'(20 + i), b: 128'd2});
    end
    wait_done("fair", 120);
    chk("fair_ngnt", 256'(glog_id.size()), 256'(6));
    if (glog_id.size() == 6)
      for (int i = 0; i < 6; i++) chk("fair_order", 256'(glog_id[i]), 256'(1 + (i % 2)));

    // Operand stability: operands become junk right after the grant.
    do_reset();
    rq[0].push_back('{a: 128'd5, b: 128'd7});
    wait_done("stable", 60);
    chk("stable_nrsp", 256'(rlog_r.size()), 256'(1));
    if (rlog_r.size() == 1) chk("stable_r", rlog_r[0], 256'd35);

    // Reset in the first BUSY cycle, stray finish afterwards.
    do_reset();
    rq[0].push_back('{a: 128'd100, b: 128'd100});
    g = -1;
    for (int n = 0; n < 20 && g < 0; n++) begin
      @(posedge clk); #2;
      if (glog_c.size() > 0) g = glog_c[0];
    end
    if (g < 0) begin
      tests++;
      fails++;
      $display("FAIL rst_mid grant timeout: got none, expected a grant");
    end else begin
      while (cyc < g + 2) begin @(posedge clk); #2; end
      rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      clear_logs();
      rq[0].push_back('{a: 128'd6, b: 128'd7});
      rq[1].push_back('{a: 128'd8, b: 128'd9});
      wait_done("rst_mid", 80);
      chk("rst_mid_nrsp", 256'(rlog_r.size()), 256'(2));
      if (glog_id.size() == 2 && rlog_r.size() == 2) begin
        chk("rst_first_gnt", 256'(glog_id[0]), 256'(0));
        chk("rst_r0", rlog_r[0], 256'd42);
        chk("rst_r1", rlog_r[1], 256'd72);
      end
    end

    // Back-to-back single requester: issue pulses exactly one period apart.
    do_reset();
    for (int i = 0; i < 6; i++) rq[2].push_back('{a: 128'(i + 1), b: 128'(i + 2)});
    wait_done("b2b", 120);
    chk("b2b_npulse", 256'(mlog_c.size()), 256'(6));
    if (mlog_c.size() == 6 && rlog_id.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk("b2b_rid", 256'(rlog_id[i]), 256'(2));
        chk("b2b_r", rlog_r[i], 256'((i + 1) * (i + 2)));
        if (i > 0) chk("b2b_gap", 256'(mlog_c[i] - mlog_c[i-1]), 256'(PERIOD));
      end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
